// File: rtl/crossing_sequencer.sv
// Pelican-crossing sequencer: car/pedestrian lamp controller driven by a pedestrian push button.
// Latency: the button edge reaches the pending latch 4 cycles after request rises; lamps are registered.
// No backpressure: request is a raw asynchronous level, and presses that arrive while pedestrians are served are dropped.
//
// Ports:
//   clk_100MHz        sole clock, rising edge
//   reset             asynchronous active-low reset
//   request           raw pedestrian button (asynchronous)
//   car_red/amber/green, pedestrian_red/green   registered lamp drives
//   ped_wait          pedestrian request latched and waiting to be served
//   phase             current state code (debug)
module crossing_sequencer #(
  parameter int TICK_DIV    = 100000000,
  parameter int T_MIN_GREEN = 10,
  parameter int T_AMBER     = 3,
  parameter int T_ALL_RED   = 1,
  parameter int T_WALK      = 8,
  parameter int T_CLEAR     = 4
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       request,
  output logic       car_red,
  output logic       car_amber,
  output logic       car_green,
  output logic       pedestrian_red,
  output logic       pedestrian_green,
  output logic       ped_wait,
  output logic [2:0] phase
);

  localparam int T_MAX_A = (T_MIN_GREEN > T_AMBER) ? T_MIN_GREEN : T_AMBER;
  localparam int T_MAX_B = (T_ALL_RED > T_WALK) ? T_ALL_RED : T_WALK;
  localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int T_MAX   = (T_MAX_C > T_CLEAR) ? T_MAX_C : T_CLEAR;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // One spare bit above max(T_*) so the saturating count in CAR_GREEN
  // always sits strictly above every threshold it is compared against.
  localparam int TW = $clog2(T_MAX + 1) + 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    CAR_GREEN = 3'd0,
    CAR_AMBER = 3'd1,
    ALL_RED1  = 3'd2,
    PED_WALK  = 3'd3,
    PED_CLEAR = 3'd4,
    ALL_RED2  = 3'd5
  } state_t;

  state_t        state, state_d;
  logic [PW-1:0] presc, presc_d;
  logic [TW-1:0] tick_cnt, tick_d;
  logic          pending, pending_d;
  logic          sync1, sync2, sync3, edge_q;
  logic          tick_wrap;
  logic          accept;

  // Next-state, counter and pending-latch computation.
  always_comb begin
    tick_wrap = (presc == PRESC_LAST);
    state_d   = state;

    case (state)
      CAR_GREEN: if (pending && (tick_cnt >= TW'(T_MIN_GREEN))) state_d = CAR_AMBER;
      CAR_AMBER: if (tick_wrap && (tick_cnt == TW'(T_AMBER - 1)))   state_d = ALL_RED1;
      ALL_RED1:  if (tick_wrap && (tick_cnt == TW'(T_ALL_RED - 1))) state_d = PED_WALK;
      PED_WALK:  if (tick_wrap && (tick_cnt == TW'(T_WALK - 1)))    state_d = PED_CLEAR;
      PED_CLEAR: if (tick_wrap && (tick_cnt == TW'(T_CLEAR - 1)))   state_d = ALL_RED2;
      ALL_RED2:  if (tick_wrap && (tick_cnt == TW'(T_ALL_RED - 1))) state_d = CAR_GREEN;
      default:   state_d = CAR_GREEN;
    endcase

    // Every state entry restarts both counters, so a state of T ticks
    // lasts exactly T*TICK_DIV cycles.
    if (state_d != state) begin
      presc_d = '0;
      tick_d  = '0;
    end else if (tick_wrap) begin
      presc_d = '0;
      // Only CAR_GREEN can run past its threshold; hold at all-ones there.
      tick_d  = (tick_cnt == '1) ? tick_cnt : tick_cnt + 1'b1;
    end else begin
      presc_d = presc + 1'b1;
      tick_d  = tick_cnt;
    end

    // Presses count only before the pedestrians are committed to; the
    // state used here is the pre-transition one.
    accept = edge_q && ((state == CAR_GREEN) || (state == CAR_AMBER) || (state == ALL_RED1));

    if ((state_d == PED_WALK) && (state != PED_WALK)) begin
      pending_d = 1'b0;
    end else if (accept) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending;
    end
  end

  // State, counters, synchronizer and lamps. Lamps are decoded from the
  // next state so they change on the same edge as the state register.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state            <= CAR_GREEN;
      presc            <= '0;
      tick_cnt         <= '0;
      pending          <= 1'b0;
      sync1            <= 1'b0;
      sync2            <= 1'b0;
      sync3            <= 1'b0;
      edge_q           <= 1'b0;
      car_red          <= 1'b0;
      car_amber        <= 1'b0;
      car_green        <= 1'b1;
      pedestrian_red   <= 1'b1;
      pedestrian_green <= 1'b0;
    end else begin
      state            <= state_d;
      presc            <= presc_d;
      tick_cnt         <= tick_d;
      pending          <= pending_d;
      // sync1/sync2 resolve metastability; sync3 is the edge detector history.
      sync1            <= request;
      sync2            <= sync1;
      sync3            <= sync2;
      edge_q           <= sync2 & ~sync3;
      car_green        <= (state_d == CAR_GREEN);
      car_amber        <= (state_d == CAR_AMBER);
      car_red          <= (state_d != CAR_GREEN) && (state_d != CAR_AMBER);
      pedestrian_green <= (state_d == PED_WALK) || ((state_d == PED_CLEAR) && !tick_d[0]);
      pedestrian_red   <= (state_d != PED_WALK) && (state_d != PED_CLEAR);
    end
  end

  assign ped_wait = pending;
  assign phase    = state;

endmodule

// File: tb/tb_crossing_sequencer.sv
module tb_crossing_sequencer;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b0;
  logic       request    = 1'b0;
  logic       car_red, car_amber, car_green;
  logic       pedestrian_red, pedestrian_green;
  logic       ped_wait;
  logic [2:0] phase;

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int conflicts = 0;
  int bad       = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  crossing_sequencer #(
    .TICK_DIV   (10),
    .T_MIN_GREEN(2),
    .T_AMBER    (1),
    .T_ALL_RED  (1),
    .T_WALK     (2),
    .T_CLEAR    (2)
  ) dut (
    .clk_100MHz      (clk_100MHz),
    .reset           (reset),
    .request         (request),
    .car_red         (car_red),
    .car_amber       (car_amber),
    .car_green       (car_green),
    .pedestrian_red  (pedestrian_red),
    .pedestrian_green(pedestrian_green),
    .ped_wait        (ped_wait),
    .phase           (phase)
  );

  wire [8:0] obs = {car_red, car_amber, car_green, pedestrian_red,
                    pedestrian_green, ped_wait, phase};

  function automatic logic [8:0] vec(input logic cr, input logic ca, input logic cg,
                                     input logic pr, input logic pg, input logic w,
                                     input logic [2:0] ph);
    return {cr, ca, cg, pr, pg, w, ph};
  endfunction

  // Expected lamp/indicator vectors: {car_red,car_amber,car_green,ped_red,ped_green,ped_wait,phase}
  logic [8:0] v_idle, v_cg_w, v_amb_w, v_ar1_w, v_walk, v_clr_on, v_clr_off, v_ar2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycle k = sampled at the falling edge following the k-th rising edge after release.
  task automatic run_to(input int k);
    while (cyc < k) begin
      @(negedge clk_100MHz);
      cyc++;
    end
  endtask

  task automatic at(input int k, input string tag, input logic [8:0] exp);
    run_to(k);
    chk(tag, {23'd0, obs}, {23'd0, exp});
  endtask

  task automatic do_reset();
    @(negedge clk_100MHz);
    reset = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b1;
    cyc   = 0;
  endtask

  // Press the button: rises after cycle a, falls after cycle b.
  task automatic press(input int a, input int b);
    run_to(a);
    request = 1'b1;
    run_to(b);
    request = 1'b0;
  endtask

  always @(negedge clk_100MHz)
    if (car_green === 1'b1 && pedestrian_green === 1'b1) conflicts++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    v_idle    = vec(0, 0, 1, 1, 0, 0, 3'd0);
    v_cg_w    = vec(0, 0, 1, 1, 0, 1, 3'd0);
    v_amb_w   = vec(0, 1, 0, 1, 0, 1, 3'd1);
    v_ar1_w   = vec(1, 0, 0, 1, 0, 1, 3'd2);
    v_walk    = vec(1, 0, 0, 0, 1, 0, 3'd3);
    v_clr_on  = vec(1, 0, 0, 0, 1, 0, 3'd4);
    v_clr_off = vec(1, 0, 0, 0, 0, 0, 3'd4);
    v_ar2     = vec(1, 0, 0, 1, 0, 0, 3'd5);

    // Outputs while reset is held from power-up.
    #12;
    chk("reset_outputs", {23'd0, obs}, {23'd0, v_idle});
    @(negedge clk_100MHz);
    reset = 1'b1;
    cyc   = 0;

    // Idle: 1000 cycles with no request must never leave CAR_GREEN.
    for (int i = 1; i <= 1000; i++) begin
      run_to(i);
      if (obs !== v_idle) bad++;
    end
    chk("idle_1000_bad_cycles", bad, 0);

    // Press long after min green expired: pending at 1004, amber at 1005.
    run_to(1000);
    request = 1'b1;
    at(1003, "late_press_no_wait_yet", v_idle);
    at(1004, "late_press_pending", v_cg_w);
    at(1005, "late_press_amber_next", v_amb_w);
    request = 1'b0;

    // Full pedestrian cycle from a press after cycle 10; second press in WALK dropped.
    do_reset();
    press(10, 13);
    at(13, "wait_before_edge", v_idle);
    at(14, "wait_set", v_cg_w);
    at(20, "min_green_last", v_cg_w);
    at(21, "amber_entry", v_amb_w);
    at(30, "amber_last", v_amb_w);
    at(31, "all_red1_entry", v_ar1_w);
    at(40, "all_red1_last", v_ar1_w);
    at(41, "walk_entry_clears_wait", v_walk);
    press(45, 47);
    at(50, "walk_press_ignored", v_walk);
    at(60, "walk_last", v_walk);
    at(61, "clear_entry_on", v_clr_on);
    at(70, "clear_tick0_on", v_clr_on);
    at(71, "clear_tick1_off", v_clr_off);
    at(80, "clear_last_off", v_clr_off);
    at(81, "all_red2_entry", v_ar2);
    at(90, "all_red2_last", v_ar2);
    at(91, "car_green_return", v_idle);
    at(300, "car_green_holds", v_idle);

    // Extra press during amber keeps one request; press in ALL_RED2 dropped.
    do_reset();
    press(10, 13);
    press(24, 26);
    at(30, "amber_extra_press", v_amb_w);
    at(40, "wait_held_to_walk", v_ar1_w);
    at(41, "wait_cleared_walk", v_walk);
    press(82, 84);
    at(91, "second_return", v_idle);
    at(200, "single_ped_phase", v_idle);

    // Reset asserted mid-WALK takes effect immediately.
    do_reset();
    press(10, 13);
    at(50, "pre_reset_walk", v_walk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_mid_walk", {23'd0, obs}, {23'd0, v_idle});
    @(negedge clk_100MHz);
    reset = 1'b1;
    cyc   = 0;
    at(100, "after_reset_no_pending", v_idle);

    // Release reset with the button already held: exactly one edge.
    @(negedge clk_100MHz);
    reset   = 1'b0;
    request = 1'b1;
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b1;
    cyc   = 0;
    at(3, "held_button_no_wait_3", v_idle);
    at(4, "held_button_wait_4", v_cg_w);
    at(41, "held_button_walk", v_walk);
    at(91, "held_button_return", v_idle);
    at(200, "held_button_single_edge", v_idle);
    request = 1'b0;

    chk("no_green_conflict", conflicts, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
